// File: rtl/rib_xbar.sv
// rib_xbar: parametrised shared-bus crossbar between NUM_MASTERS masters and NUM_SLAVES slaves.
// One transfer at a time: IDLE (arbitrate, grant) -> BUSY (slave access, wait states,
// optional timeout) -> RESP (one-cycle completion) -> IDLE.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_req_i/m_we_i           per-master request and write enable
//   m_addr_i/m_wdata_i       packed per-master address / write data (master k at slice k)
//   m_gnt_o                  combinational one-cycle grant pulse in IDLE
//   m_rvalid_o/m_err_o       completion pulse and error qualifier for the owning master
//   m_rdata_o                packed read data, only the owner's slice is non-zero in RESP
//   s_req_o                  one-hot slave request during BUSY
//   s_we_o/s_addr_o/s_wdata_o  latched transfer attributes shared by all slaves
//   s_rdata_i/s_ready_i      packed slave read data and per-slave ready
//   hold_flag_o              high whenever a transfer is in flight
module rib_xbar #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned NUM_SLAVES     = 6,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_BITS       = 4,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic [NUM_SLAVES-1:0]             s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata_i,
  input  logic [NUM_SLAVES-1:0]             s_ready_i,
  output logic                              hold_flag_o
);

  localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [MW-1:0]           owner_q, owner_d;
  logic [MW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [SEL_BITS-1:0]     sel_q, sel_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [15:0]             cnt_q, cnt_d;

  // Arbitration
  logic                    any_req;
  logic [MW-1:0]           arb_base;
  logic [NUM_MASTERS-1:0]  req_rot;
  logic                    found;
  logic [MW:0]             win_sum;
  logic [MW-1:0]           win;
  logic                    win_we;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [SEL_BITS-1:0]     win_sel;
  logic                    win_mapped;

  // Both modes share one first-set search: fixed priority is round-robin with base 0.
  always_comb begin
    any_req  = |m_req_i;
    arb_base = (ARB_MODE == 0) ? '0 : rr_ptr_q;
    req_rot  = NUM_MASTERS'({m_req_i, m_req_i} >> arb_base);
    found    = 1'b0;
    win_sum  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_sum = {1'b0, arb_base} + (MW+1)'(i);
      end
    end
    if (win_sum >= (MW+1)'(NUM_MASTERS)) begin
      win_sum = win_sum - (MW+1)'(NUM_MASTERS);
    end
    win = win_sum[MW-1:0];

    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win == MW'(i)) begin
        win_we    = m_we_i[i];
        win_addr  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    win_sel    = win_addr[ADDR_WIDTH-1 -: SEL_BITS];
    win_mapped = (32'(win_sel) < NUM_SLAVES);
  end

  // Selected slave's response
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (sel_q == SEL_BITS'(j)) begin
        sel_ready = s_ready_i[j];
        sel_rdata = s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // cnt_q counts completed BUSY cycles, so the Nth BUSY cycle sees N-1.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = win;
          sel_d   = win_sel;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (win_mapped) begin
            state_d = StBusy;
            err_d   = 1'b0;
          end else begin
            // Unmapped: answer directly, no slave sees the access.
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 16'd1;
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d  = StIdle;
        rr_ptr_d = (owner_q == MW'(NUM_MASTERS - 1)) ? '0 : owner_q + MW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs
  always_comb begin
    hold_flag_o = (state_q != StIdle);
    s_we_o      = we_q;
    s_addr_o    = addr_q;
    s_wdata_o   = wdata_q;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      s_req_o[j] = (state_q == StBusy) && (sel_q == SEL_BITS'(j));
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // Grant is combinational; gate with rst so it is quiet while reset is held.
      m_gnt_o[i]    = !rst && (state_q == StIdle) && any_req && (win == MW'(i));
      m_rvalid_o[i] = (state_q == StResp) && (owner_q == MW'(i));
      m_err_o[i]    = m_rvalid_o[i] && err_q;
      m_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = m_rvalid_o[i] ? rdata_q : '0;
    end
  end

endmodule

// File: tb/tb_rib_xbar.sv
module tb_rib_xbar;

  localparam int unsigned NM = 4;
  localparam int unsigned NS = 6;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_req, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [DW-1:0]    slave_data [NS];

  // Round-robin instance (main scoreboarded DUT)
  logic [NM-1:0]    gnt_rr, rvalid_rr, err_rr;
  logic [NM*DW-1:0] rdata_rr;
  logic [NS-1:0]    sreq_rr, sready_rr;
  logic             swe_rr, hold_rr;
  logic [AW-1:0]    saddr_rr;
  logic [DW-1:0]    swdata_rr;

  // Fixed-priority instance, same master stimulus, zero-wait slaves
  logic [NM-1:0]    gnt_fp, rvalid_fp, err_fp;
  logic [NM*DW-1:0] rdata_fp;
  logic [NS-1:0]    sreq_fp;
  logic             swe_fp, hold_fp;
  logic [AW-1:0]    saddr_fp;
  logic [DW-1:0]    swdata_fp;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  wait_cfg;
  bit  never_ready;
  bit  stray;
  int  busy_cnt;

  typedef struct {
    int          master;
    bit          err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
             .SEL_BITS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_gnt_o(gnt_rr), .m_rvalid_o(rvalid_rr), .m_err_o(err_rr),
    .m_rdata_o(rdata_rr), .s_req_o(sreq_rr), .s_we_o(swe_rr), .s_addr_o(saddr_rr),
    .s_wdata_o(swdata_rr), .s_rdata_i(s_rdata), .s_ready_i(sready_rr), .hold_flag_o(hold_rr)
  );

  rib_xbar #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
             .SEL_BITS(4), .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fp (
    .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_gnt_o(gnt_fp), .m_rvalid_o(rvalid_fp), .m_err_o(err_fp),
    .m_rdata_o(rdata_fp), .s_req_o(sreq_fp), .s_we_o(swe_fp), .s_addr_o(saddr_fp),
    .s_wdata_o(swdata_fp), .s_rdata_i(s_rdata), .s_ready_i(sreq_fp), .hold_flag_o(hold_fp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int j = 0; j < NS; j++) s_rdata[j*DW +: DW] = slave_data[j];
  end

  // Slave model: ready after wait_cfg stalled cycles; stray readies on unselected slaves.
  assign sready_rr = ((!never_ready && busy_cnt == wait_cfg) ? sreq_rr : '0) |
                     (stray ? ~sreq_rr : '0);

  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if ((|sreq_rr) && !(|(sready_rr & sreq_rr))) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
  end

  // Scoreboard: push the expected response at grant, compare at completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt_rr != '0) begin
        n_checks++;
        if (!$onehot(gnt_rr)) begin
          n_fail++;
          $display("FAIL gnt_onehot got=%b want one-hot", gnt_rr);
        end
        for (int k = 0; k < NM; k++) begin
          if (gnt_rr[k]) begin
            exp_t        e;
            logic [31:0] a;
            int          sel;
            a        = m_addr[k*AW +: AW];
            sel      = int'(a[31:28]);
            e.master = k;
            e.err    = (sel >= NS) || never_ready || (wait_cfg >= TO);
            e.data   = '0;
            if (!e.err && !m_we[k]) e.data = slave_data[sel];
            sb_q.push_back(e);
          end
        end
      end
      if (rvalid_rr != '0) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected got rvalid=%b want none", rvalid_rr);
        end else begin
          exp_t             e;
          logic [NM-1:0]    ev, ee;
          logic [NM*DW-1:0] ed;
          e  = sb_q.pop_front();
          ev = '0;
          ee = '0;
          ed = '0;
          ev[e.master] = 1'b1;
          ee[e.master] = e.err;
          ed[e.master*DW +: DW] = e.data;
          if (rvalid_rr !== ev || err_rr !== ee || rdata_rr !== ed) begin
            n_fail++;
            $display("FAIL sb_resp got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                     rvalid_rr, err_rr, rdata_rr, ev, ee, ed);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit we, input logic [31:0] a, input logic [31:0] wd);
    m_req[k]            = 1'b1;
    m_we[k]             = we;
    m_addr[k*AW +: AW]  = a;
    m_wdata[k*DW +: DW] = wd;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < 60 && (hold_rr || hold_fp || sb_q.size() != 0)) begin
      tick();
      t++;
    end
    tick();
    n_checks++;
    if (hold_rr || hold_fp || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_timeout got hold_rr=%b hold_fp=%b pending=%0d want idle",
               hold_rr, hold_fp, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    m_req = '1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({hold_rr, sreq_rr, rvalid_rr, err_rr, rdata_rr, swe_rr, saddr_rr, swdata_rr,
         gnt_rr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got hold=%b sreq=%b rvalid=%b gnt=%b want all 0",
               hold_rr, sreq_rr, rvalid_rr, gnt_rr);
    end
    n_checks++;
    if ({hold_fp, gnt_fp, rvalid_fp, sreq_fp} !== '0) begin
      n_fail++;
      $display("FAIL reset_fp got hold=%b gnt=%b want 0", hold_fp, gnt_fp);
    end
    m_req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_rr();
    int order[5];
    int at[5];
    int n   = 0;
    bit bad = 0;
    wait_cfg = 0;
    for (int k = 0; k < NM; k++) set_req(k, 1'b0, (32'(k) << 28) | 32'h100, 32'h0);
    for (int t = 0; t < 40 && n < 5; t++) begin
      @(negedge clk);
      if (gnt_rr != '0) begin
        for (int k = 0; k < NM; k++) if (gnt_rr[k]) order[n] = k;
        at[n] = cyc;
        n++;
      end
    end
    tick();
    m_req = '0;
    n_checks++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL rr_count got=%0d want=5", n);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (order[i] != i % 4) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got=m%0d want=m%0d", i, order[i], i % 4);
      end
    end
    for (int i = 1; i < n; i++) if (at[i] - at[i-1] != 3) bad = 1;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rr_spacing got irregular gaps want 3 cycles");
    end
    wait_idle();
  endtask

  task automatic test_fixed();
    int          n   = 0;
    bit          bad = 0;
    logic [NM-1:0] g1, g2, g3;
    set_req(0, 1'b0, 32'h0000_0200, 32'h0);
    set_req(2, 1'b0, 32'h2000_0200, 32'h0);
    for (int t = 0; t < 20 && n < 3; t++) begin
      @(negedge clk);
      if (gnt_fp != '0) begin
        n++;
        if (gnt_fp !== 4'b0001) bad = 1;
      end
    end
    n_checks++;
    if (n != 3 || bad) begin
      n_fail++;
      $display("FAIL fixed_m0_only got grants=%0d stray=%b want 3 grants to m0", n, bad);
    end
    tick();
    m_req[0] = 1'b0;
    @(negedge clk); g1 = gnt_fp;
    @(negedge clk); g2 = gnt_fp;
    @(negedge clk); g3 = gnt_fp;
    n_checks++;
    if (g1 !== 4'b0000 || g2 !== 4'b0000 || g3 !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_m2_next got=%b,%b,%b want=0000,0000,0100", g1, g2, g3);
    end
    tick();
    m_req[2] = 1'b0;
    wait_idle();
  endtask

  task automatic test_read();
    bit bad = 0;
    wait_cfg = 2;
    set_req(1, 1'b0, 32'h1000_0040, 32'h0);
    @(negedge clk);
    n_checks++;
    if (gnt_rr !== 4'b0010 || hold_rr !== 1'b0) begin
      n_fail++;
      $display("FAIL read_gnt got gnt=%b hold=%b want gnt=0010 hold=0", gnt_rr, hold_rr);
    end
    tick();
    m_req[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (sreq_rr !== 6'b000010 || hold_rr !== 1'b1 || rvalid_rr !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL read_busy got sreq=%b hold=%b want sreq=000010 for 3 cycles", sreq_rr,
               hold_rr);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid_rr !== 4'b0010 || err_rr !== 4'b0000 || rdata_rr[DW +: DW] !== 32'hDEADBEEF ||
        hold_rr !== 1'b1) begin
      n_fail++;
      $display("FAIL read_resp got rvalid=%b err=%b rdata=%h hold=%b want 0010 0000 deadbeef 1",
               rvalid_rr, err_rr, rdata_rr[DW +: DW], hold_rr);
    end
    @(negedge clk);
    n_checks++;
    if (hold_rr !== 1'b0) begin
      n_fail++;
      $display("FAIL read_release got hold=%b want 0", hold_rr);
    end
    wait_cfg = 0;
    wait_idle();
  endtask

  task automatic test_decode();
    set_req(0, 1'b1, 32'h7000_0000, 32'h1234_5678);
    @(negedge clk);
    n_checks++;
    if (gnt_rr !== 4'b0001) begin
      n_fail++;
      $display("FAIL decode_gnt got=%b want=0001", gnt_rr);
    end
    tick();
    m_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sreq_rr !== '0 || rvalid_rr !== 4'b0001 || err_rr !== 4'b0001 || rdata_rr !== '0) begin
      n_fail++;
      $display("FAIL decode_err got sreq=%b rvalid=%b err=%b rdata=%h want 0 0001 0001 0",
               sreq_rr, rvalid_rr, err_rr, rdata_rr);
    end
    wait_idle();
  endtask

  task automatic test_write();
    wait_cfg = 1;
    set_req(2, 1'b1, 32'h4000_0008, 32'hCAFE_F00D);
    @(negedge clk);
    tick();
    m_req[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sreq_rr !== 6'b010000 || swe_rr !== 1'b1 || saddr_rr !== 32'h4000_0008 ||
        swdata_rr !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL write_bus got sreq=%b we=%b addr=%h wdata=%h want 010000 1 40000008 cafef00d",
               sreq_rr, swe_rr, saddr_rr, swdata_rr);
    end
    wait_cfg = 0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int hi = 0;
    never_ready = 1'b1;
    stray       = 1'b1;
    set_req(3, 1'b0, 32'h2000_0010, 32'h0);
    @(negedge clk);
    tick();
    m_req[3] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (sreq_rr === 6'b000100) hi++;
    end
    n_checks++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL timeout_busy got sreq cycles=%0d want=4", hi);
    end
    @(negedge clk);
    n_checks++;
    if (sreq_rr !== '0 || rvalid_rr !== 4'b1000 || err_rr !== 4'b1000 || rdata_rr !== '0) begin
      n_fail++;
      $display("FAIL timeout_resp got sreq=%b rvalid=%b err=%b rdata=%h want 0 1000 1000 0",
               sreq_rr, rvalid_rr, err_rr, rdata_rr);
    end
    never_ready = 1'b0;
    stray       = 1'b0;
    wait_idle();
    // Ready lands on the timeout cycle itself: must complete cleanly.
    wait_cfg = 3;
    set_req(3, 1'b0, 32'h2000_0010, 32'h0);
    @(negedge clk);
    tick();
    m_req[3] = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (rvalid_rr !== 4'b1000 || err_rr !== 4'b0000 || rdata_rr[3*DW +: DW] !== slave_data[2]) begin
      n_fail++;
      $display("FAIL timeout_edge got rvalid=%b err=%b rdata=%h want 1000 0000 %h",
               rvalid_rr, err_rr, rdata_rr[3*DW +: DW], slave_data[2]);
    end
    wait_cfg = 0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    wait_cfg = 0;
    set_req(1, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    tick();
    m_req[1] = 1'b0;
    wait_idle();
    never_ready = 1'b1;
    set_req(2, 1'b0, 32'h3000_0000, 32'h0);
    @(negedge clk);
    tick();
    m_req[2] = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    n_checks++;
    if (sreq_rr !== '0 || hold_rr !== 1'b0 || rvalid_rr !== '0 || gnt_rr !== '0 ||
        saddr_rr !== '0 || hold_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got sreq=%b hold=%b rvalid=%b addr=%h hold_fp=%b want all 0",
               sreq_rr, hold_rr, rvalid_rr, saddr_rr, hold_fp);
    end
    never_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NM; k++) set_req(k, 1'b0, (32'(k) << 28) | 32'h8, 32'h0);
    @(negedge clk);
    n_checks++;
    if (gnt_rr !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_rr_restart got=%b want=0001", gnt_rr);
    end
    tick();
    m_req = '0;
    wait_idle();
  endtask

  initial begin
    m_req       = '0;
    m_we        = '0;
    m_addr      = '0;
    m_wdata     = '0;
    wait_cfg    = 0;
    never_ready = 1'b0;
    stray       = 1'b0;
    for (int j = 0; j < NS; j++) slave_data[j] = 32'h5A00_0000 | 32'(j * 32'h111);
    slave_data[1] = 32'hDEADBEEF;

    test_reset();
    test_rr();
    test_fixed();
    test_read();
    test_decode();
    test_write();
    test_timeout();
    test_reset_mid();

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
